// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if
// Bundles the request port, the HI/LO result port and the link to the
// team's unsigned iterative divider for hilo_muldiv.
//
// Signals:
//   req_valid / req_ready     request handshake (accept = valid & ready)
//   req_op [OP_W]             0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO
//   req_a / req_b [32]        rs / rt operands
//   busy                      ~req_ready, stalls HI/LO readers
//   hi / lo [32]              architectural HI/LO registers
//   div_valid                 one-cycle start pulse to the divider
//   div_a / div_b [32]        unsigned dividend / divisor
//   div_done                  divider idle/complete (combinational)
//   div_c [64]                {remainder, quotient} from the divider
//
// Modports:
//   slave  - the hilo_muldiv block
//   master - the execute stage plus divider side that surrounds it
interface hilo_muldiv_if #(
   parameter int OP_W = 3
);
   logic            req_valid;
   logic            req_ready;
   logic [OP_W-1:0] req_op;
   logic [31:0]     req_a;
   logic [31:0]     req_b;
   logic            busy;
   logic [31:0]     hi;
   logic [31:0]     lo;
   logic            div_valid;
   logic [31:0]     div_a;
   logic [31:0]     div_b;
   logic            div_done;
   logic [63:0]     div_c;

   modport slave (
      input  req_valid, req_op, req_a, req_b, div_done, div_c,
      output req_ready, busy, hi, lo, div_valid, div_a, div_b
   );

   modport master (
      output req_valid, req_op, req_a, req_b, div_done, div_c,
      input  req_ready, busy, hi, lo, div_valid, div_a, div_b
   );
endinterface

// File: rtl/hilo_muldiv.sv
// hilo_muldiv
// Owns the HI/LO register pair and sequences MULT, MULTU, DIV, DIVU, MTHI
// and MTLO for the execute stage. Multiplies run through a 2-stage product
// register; divides are reduced to unsigned magnitudes, handed to the
// external unsigned divider and sign-corrected on return.
//
// Ports:
//   clk      clock
//   resetn   asynchronous active-low reset
//   bus      hilo_muldiv_if.slave (request, HI/LO, divider link)
//
// Build option:
//   HILO_DIV_BYPASS_EN  when defined, a divide whose divisor magnitude
//                       exceeds its dividend magnitude completes at the
//                       accept edge (lo=0, hi=req_a) without the divider.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request; MTHI/MTLO/div-by-zero finish here
// MUL1   | operands latched, product being registered
// MUL2   | product written to {hi,lo}
// ISSUE  | div_valid pulse, divider starts
// WAIT   | waiting for div_done
// FIX    | sign-correct quotient/remainder into lo/hi
module hilo_muldiv #(
   parameter int OP_W = 3
) (
   input  logic         clk,
   input  logic         resetn,
   hilo_muldiv_if.slave bus
);

   localparam logic [OP_W-1:0] OP_MULT  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_MULTU = OP_W'(1);
   localparam logic [OP_W-1:0] OP_DIV   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(5);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MUL1  = 3'd1,
      MUL2  = 3'd2,
      ISSUE = 3'd3,
      WAIT  = 3'd4,
      FIX   = 3'd5
   } state_t;

   state_t      state;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        mul_signed;
   logic [63:0] product;
   logic        sign_q;
   logic        sign_r;
   logic [31:0] div_a_q;
   logic [31:0] div_b_q;
   logic        div_valid_q;
   logic        ready_q;

   logic        accept;
   logic        signed_div;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic        bypass;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [31:0] quo;
   logic [31:0] rem;

   assign accept     = bus.req_valid & ready_q;
   assign signed_div = (bus.req_op == OP_DIV);

   // 32-bit magnitudes: |0x80000000| wraps back to 0x80000000, which is the
   // correct unsigned magnitude.
   assign mag_a = (signed_div & bus.req_a[31]) ? (~bus.req_a + 32'd1) : bus.req_a;
   assign mag_b = (signed_div & bus.req_b[31]) ? (~bus.req_b + 32'd1) : bus.req_b;

`ifdef HILO_DIV_BYPASS_EN
   // Quotient is known zero and remainder is the raw dividend.
   assign bypass = (mag_b > mag_a);
`else
   assign bypass = 1'b0;
`endif

   // Sign-extending to 64 bits makes the low 64 bits of one unsigned
   // multiply correct for both MULT and MULTU.
   assign ext_a = {{32{mul_signed & op_a[31]}}, op_a};
   assign ext_b = {{32{mul_signed & op_b[31]}}, op_b};

   assign quo = bus.div_c[31:0];
   assign rem = bus.div_c[63:32];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         hi_q        <= '0;
         lo_q        <= '0;
         op_a        <= '0;
         op_b        <= '0;
         mul_signed  <= 1'b0;
         product     <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         div_a_q     <= '0;
         div_b_q     <= '0;
         div_valid_q <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bus.req_op == OP_MULT || bus.req_op == OP_MULTU) begin
                     op_a       <= bus.req_a;
                     op_b       <= bus.req_b;
                     mul_signed <= (bus.req_op == OP_MULT);
                     ready_q    <= 1'b0;
                     state      <= MUL1;
                  end else if (bus.req_op == OP_DIV || bus.req_op == OP_DIVU) begin
                     if (bus.req_b == 32'd0) begin
                        hi_q <= bus.req_a;
                        lo_q <= 32'hFFFF_FFFF;
                     end else if (bypass) begin
                        hi_q <= bus.req_a;
                        lo_q <= 32'd0;
                     end else begin
                        div_a_q     <= mag_a;
                        div_b_q     <= mag_b;
                        sign_q      <= signed_div & (bus.req_a[31] ^ bus.req_b[31]);
                        sign_r      <= signed_div & bus.req_a[31];
                        div_valid_q <= 1'b1;
                        ready_q     <= 1'b0;
                        state       <= ISSUE;
                     end
                  end else if (bus.req_op == OP_MTHI) begin
                     hi_q <= bus.req_a;
                  end else if (bus.req_op == OP_MTLO) begin
                     lo_q <= bus.req_a;
                  end
                  // ops 6/7 are accepted and dropped
               end
            end
            MUL1: begin
               product <= ext_a * ext_b;
               state   <= MUL2;
            end
            MUL2: begin
               hi_q    <= product[63:32];
               lo_q    <= product[31:0];
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            ISSUE: begin
               div_valid_q <= 1'b0;
               state       <= WAIT;
            end
            WAIT: begin
               if (bus.div_done) begin
                  state <= FIX;
               end
            end
            FIX: begin
               lo_q    <= sign_q ? (32'd0 - quo) : quo;
               hi_q    <= sign_r ? (32'd0 - rem) : rem;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               ready_q     <= 1'b1;
               div_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.busy      = ~ready_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.div_valid = div_valid_q;
   assign bus.div_a     = div_a_q;
   assign bus.div_b     = div_b_q;

endmodule
